inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Builds 32-bit RISC-V instruction words from structured fields: opcode, type, funct3/funct7, register indices and a full-width immediate.
- Also expands the LI pseudo-op into a LUI/ADDI(W) sequence.
- Feeds generated code (trap stubs, self-test sequences, fence.i patch-up) into the fetch path or instruction memory.
- Field layout and immediate scrambling are exactly those the decoder inverts.

Parameters:
XLEN, 32, register/immediate width; 32 or 64 only.

Ports:
clock  in  1  single clock; all state on rising edge
reset_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request present
in_ready  out  1  encoder accepts request this cycle
in_pseudo  in  1  0 = raw encode, 1 = LI rd, imm
in_itype  in  3  TYPE_R/I/S/B/U/J code from shared defines
in_opcode  in  7  major opcode
in_funct3  in  3  funct3
in_funct7  in  7  funct7; also shift-immediate upper bits
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  XLEN  signed immediate, unscrambled byte offset/value
out_valid  out  1  out_inst valid
out_ready  in  1  consumer takes word this cycle
out_inst  out  32  encoded instruction
out_last  out  1  final word of this request
out_err  out  1  immediate not representable; word still emitted, field truncated

Behaviour:
- Reset, asynchronous on reset_n low: state IDLE; out_valid=0, out_inst=0, out_last=0, out_err=0. in_ready=1 after reset release.
- Applies mid-sequence too: a pending LI second word is discarded.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
- in_ready = (state==IDLE) || (state==FULL && out_ready && !second_pending). Accept-and-drain in the same cycle is allowed, giving full throughput of 1 word/cycle for single-word requests.
- Latency: word is registered; out_valid asserts the cycle after acceptance.
- Raw encode by in_itype:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode. For funct3 001/101 with opcode OP_IMM/OP_IMM_32, bits [31:26] = in_funct7[6:1], shamt = imm[5:0] (imm[4:0] for OP_IMM_32 or XLEN=32).
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Unknown itype: out_inst=0, out_err=1.
  - out_last=1 for all raw encodes.
- Range checks, any failure sets out_err:
  - I/S: imm sign-fits 12 bits.
  - B: sign-fits 13 bits and imm[0]=0.
  - J: sign-fits 21 bits and imm[0]=0.
  - U: imm[11:0]=0 and sign-fits 32 bits.
  - Shift: shamt in range.
- LI expansion (in_pseudo=1; other fields except rd, imm ignored):
  - lo = sign-extended imm[11:0]; hi = (imm - lo)[31:12], arithmetic on XLEN bits.
  - imm sign-fits 12: single ADDI rd,x0,lo; out_last=1.
  - else lo==0: single LUI rd,hi; out_last=1.
  - else: LUI rd,hi (out_last=0), then ADDI rd,rd,lo. On XLEN=64 the second word is ADDIW. The second word has out_last=1.
  - XLEN=64 and imm does not sign-fit 32: emit ADDI rd,x0,imm[11:0] with out_err=1, out_last=1.
- FSM states:
  - IDLE: out empty.
  - FULL: one word presented.
  - FULL2: first LI word presented, second pending. in_ready=0. On emit, load the second word and go to FULL.
- rd=x0 is encoded as given; no special casing.

Decomposition:
- Shared defines.vh: opcode and funct3 constants, TYPE_* codes, INST_NOP. Add LI-related constants there, not locally.
- One sub-module, inst_pack: combinational (itype, fields, imm) -> (word, err). Same instance used for both LI words via a field mux.

Test Plan:
- Raw I-type, opcode OP_IMM, rd=1, rs1=0, funct3=0, imm=5 -> 0x00500093, out_last=1, out_err=0, one cycle after accept.
- LI x5, 0x12345678 -> 0x123452B7 (out_last=0), then 0x67828293 (out_last=1); in_ready=0 between the two words.
- LI x1, 0x00000800 (rounding) -> 0x000010B7 then 0x80008093. LI x1, 0x1000 -> single 0x000010B7, out_last=1.
- Raw B-type with imm=3 -> out_err=1. J-type with imm=0x100000 (out of range) -> out_err=1. S-type imm=-4, rs1=2, rs2=3, funct3=010, opcode STORE -> 0xFE312E23, out_err=0.
- Back-pressure: out_ready low 3 cycles on the LI pair -> out_inst stable, no word lost or duplicated. Back-to-back raw requests with out_ready=1 -> one word per cycle.
- Assert reset_n low while FULL2 -> out_valid drops immediately, the second LI word is never emitted, in_ready=1 after release.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared encoder definitions: opcode/funct3 constants, instruction-type
// codes, LI expansion constants, the field bundle fed to inst_pack and a
// sign-fit helper used by the range checks.
package inst_encoder_pkg;

  localparam int unsigned ILEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned ITYPE_W   = 3;

  // Instruction format codes
  localparam logic [ITYPE_W-1:0] TYPE_R = 3'd0;
  localparam logic [ITYPE_W-1:0] TYPE_I = 3'd1;
  localparam logic [ITYPE_W-1:0] TYPE_S = 3'd2;
  localparam logic [ITYPE_W-1:0] TYPE_B = 3'd3;
  localparam logic [ITYPE_W-1:0] TYPE_U = 3'd4;
  localparam logic [ITYPE_W-1:0] TYPE_J = 3'd5;

  // Major opcodes
  localparam logic [OPCODE_W-1:0] OP_LUI      = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_OP       = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_OP_IMM   = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_OP_IMM_32 = 7'h1B;
  localparam logic [OPCODE_W-1:0] OP_STORE    = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_BRANCH   = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_JAL      = 7'h6F;

  // funct3 values
  localparam logic [FUNCT3_W-1:0] F3_ADDI = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLLI = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SRXI = 3'b101;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  // LI expansion constants
  localparam int unsigned         LI_LO_W   = 12;
  localparam logic [REG_W-1:0]    LI_X0     = 5'd0;
  localparam logic [FUNCT3_W-1:0] LI_F3_ADD = F3_ADDI;

  // Field bundle presented to inst_pack (immediate travels separately)
  typedef struct packed {
    logic [ITYPE_W-1:0]  itype;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
  } pack_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FULL  = 2'd1,
    ST_FULL2 = 2'd2
  } enc_state_e;

  // True when v (already sign-extended to 64 bits) fits an n-bit signed field
  function automatic logic sfits(input logic [63:0] v, input int unsigned n);
    logic signed [63:0] sh;
    sh = $signed(v) >>> (n - 1);
    return (sh == 64'sd0) || (&sh);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational instruction-word builder.
// Ports: req_i  - format, opcode, funct3/funct7 and register fields
//        imm_i  - signed, unscrambled immediate (XLEN bits)
//        word_o - encoded 32-bit instruction
//        err_o  - immediate not representable (field is still truncated in)
module inst_pack
  import inst_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  pack_req_t        req_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic [ILEN-1:0]  word_o,
  output logic             err_o
);

  logic [63:0] imm64;
  logic        is_shift;
  logic        shamt6;

  assign imm64 = 64'($signed(imm_i));

  // Shift-immediates carry funct7[6:1] above a 5- or 6-bit shamt
  assign is_shift = (req_i.itype == TYPE_I)
                 && ((req_i.opcode == OP_OP_IMM) || (req_i.opcode == OP_OP_IMM_32))
                 && ((req_i.funct3 == F3_SLLI) || (req_i.funct3 == F3_SRXI));
  assign shamt6   = (XLEN == 64) && (req_i.opcode == OP_OP_IMM);

  // Field placement and immediate scrambling per format
  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    unique case (req_i.itype)
      TYPE_R: begin
        word_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      end
      TYPE_I: begin
        if (is_shift && shamt6) begin
          word_o = {req_i.funct7[6:1], imm64[5:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
          err_o  = (imm64[63:6] != '0);
        end else if (is_shift) begin
          word_o = {req_i.funct7, imm64[4:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
          err_o  = (imm64[63:5] != '0);
        end else begin
          word_o = {imm64[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
          err_o  = !sfits(imm64, 12);
        end
      end
      TYPE_S: begin
        word_o = {imm64[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm64[4:0], req_i.opcode};
        err_o  = !sfits(imm64, 12);
      end
      TYPE_B: begin
        word_o = {imm64[12], imm64[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                  imm64[4:1], imm64[11], req_i.opcode};
        err_o  = !sfits(imm64, 13) || imm64[0];
      end
      TYPE_U: begin
        word_o = {imm64[31:12], req_i.rd, req_i.opcode};
        err_o  = (imm64[11:0] != '0) || !sfits(imm64, 32);
      end
      TYPE_J: begin
        word_o = {imm64[20], imm64[10:1], imm64[11], imm64[19:12], req_i.rd, req_i.opcode};
        err_o  = !sfits(imm64, 21) || imm64[0];
      end
      default: begin
        word_o = '0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: builds RISC-V instruction words from structured fields and
// expands LI rd, imm into ADDI / LUI / LUI+ADDI(W). One registered output
// word with valid/ready on both sides.
// Ports: clock, reset_n         - clock, async active-low reset
//        in_*                   - request handshake and fields
//        out_valid/out_ready    - output handshake
//        out_inst/out_last/out_err - encoded word, last-of-request, range error
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_pseudo,
  input  logic [ITYPE_W-1:0]  in_itype,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic [FUNCT7_W-1:0] in_funct7,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [XLEN-1:0]     in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ILEN-1:0]     out_inst,
  output logic                out_last,
  output logic                out_err
);

  enc_state_e           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [ILEN-1:0]      inst_q, inst_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [REG_W-1:0]     sec_rd_q, sec_rd_d;
  logic [LI_LO_W-1:0]   sec_lo_q, sec_lo_d;

  logic                 accept;
  logic                 emit;

  logic [63:0]          imm64;
  logic [XLEN-1:0]      lo_ext;
  logic [31:0]          hi32;
  logic [XLEN-1:0]      lui_imm;
  logic                 li_fit12;
  logic                 li_wide;
  logic                 li_use_lui;
  logic                 li_two;

  pack_req_t            pack_req;
  logic [XLEN-1:0]      pack_imm;
  logic [ILEN-1:0]      pack_word;
  logic                 pack_err;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_FULL) && out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = valid_q && out_ready;

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

  // LI split: lo is the sign-extended low 12 bits, hi absorbs the rounding
  assign imm64      = 64'($signed(in_imm));
  assign lo_ext     = XLEN'($signed(in_imm[LI_LO_W-1:0]));
  assign hi32       = 32'(in_imm - lo_ext);
  assign lui_imm    = XLEN'($signed(hi32));
  assign li_fit12   = sfits(imm64, 12);
  assign li_wide    = (XLEN == 64) && !sfits(imm64, 32);
  assign li_use_lui = !li_fit12 && !li_wide;
  assign li_two     = li_use_lui && (in_imm[LI_LO_W-1:0] != '0);

  // Field mux into the single packer: pending LI tail, LI head, or raw request
  always_comb begin
    pack_req = '0;
    pack_imm = '0;
    if (state_q == ST_FULL2) begin
      pack_req.itype  = TYPE_I;
      pack_req.opcode = (XLEN == 64) ? OP_OP_IMM_32 : OP_OP_IMM;
      pack_req.funct3 = LI_F3_ADD;
      pack_req.rd     = sec_rd_q;
      pack_req.rs1    = sec_rd_q;
      pack_imm        = XLEN'($signed(sec_lo_q));
    end else if (in_pseudo) begin
      pack_req.rd = in_rd;
      if (li_use_lui) begin
        pack_req.itype  = TYPE_U;
        pack_req.opcode = OP_LUI;
        pack_imm        = lui_imm;
      end else begin
        pack_req.itype  = TYPE_I;
        pack_req.opcode = OP_OP_IMM;
        pack_req.funct3 = LI_F3_ADD;
        pack_req.rs1    = LI_X0;
        pack_imm        = lo_ext;
      end
    end else begin
      pack_req.itype  = in_itype;
      pack_req.opcode = in_opcode;
      pack_req.funct3 = in_funct3;
      pack_req.funct7 = in_funct7;
      pack_req.rd     = in_rd;
      pack_req.rs1    = in_rs1;
      pack_req.rs2    = in_rs2;
      pack_imm        = in_imm;
    end
  end

  inst_pack #(
    .XLEN (XLEN)
  ) u_pack (
    .req_i  (pack_req),
    .imm_i  (pack_imm),
    .word_o (pack_word),
    .err_o  (pack_err)
  );

  // Next-state and output-register logic
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    last_d   = last_q;
    err_d    = err_q;
    sec_rd_d = sec_rd_q;
    sec_lo_d = sec_lo_q;

    if (state_q == ST_FULL2) begin
      // Head word leaves; the tail built from saved rd/lo replaces it
      if (emit) begin
        state_d = ST_FULL;
        inst_d  = pack_word;
        last_d  = 1'b1;
        err_d   = pack_err;
      end
    end else if (accept) begin
      valid_d  = 1'b1;
      inst_d   = pack_word;
      if (in_pseudo) begin
        state_d = li_two ? ST_FULL2 : ST_FULL;
        last_d  = !li_two;
        err_d   = pack_err || li_wide;
      end else begin
        state_d = ST_FULL;
        last_d  = 1'b1;
        err_d   = pack_err;
      end
      sec_rd_d = in_rd;
      sec_lo_d = in_imm[LI_LO_W-1:0];
    end else if (emit) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      sec_rd_q <= '0;
      sec_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      last_q   <= last_d;
      err_q    <= err_d;
      sec_rd_q <= sec_rd_d;
      sec_lo_q <= sec_lo_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (XLEN=32) with hand-computed words.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_pseudo;
  logic [2:0]      in_itype;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic            out_last;
  logic            out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  inst_encoder #(.XLEN(XLEN)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pseudo (in_pseudo),
    .in_itype  (in_itype),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ps, input logic [2:0] it, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [XLEN-1:0] imm);
    in_valid  = 1'b1;
    in_pseudo = ps;
    in_itype  = it;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Present a request and hold it until the accepting edge has passed
  task automatic req(input string tag, input logic ps, input logic [2:0] it,
                     input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [XLEN-1:0] imm);
    int n;
    drive(ps, it, op, f3, f7, rd, rs1, rs2, imm);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Check the presented word and let it drain (out_ready must be high)
  task automatic expect_word(input string tag, input logic [31:0] inst,
                             input logic last, input logic err);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_inst"},  out_inst, inst);
    chk({tag, "_last"},  32'(out_last), 32'(last));
    chk({tag, "_err"},   32'(out_err), 32'(err));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_pseudo = 1'b0;
    in_itype  = '0;
    in_opcode = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst",  out_inst, 32'd0);
    chk("rst_last",  32'(out_last), 32'd0);
    chk("rst_err",   32'(out_err), 32'd0);
    tick();
    reset_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Raw ADDI x1, x0, 5: word appears the cycle after accept
    req("addi", 1'b0, TYPE_I, OP_OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_lat", 32'(out_valid), 32'd1);
    expect_word("addi", 32'h0050_0093, 1'b1, 1'b0);
    chk("addi_drained", 32'(out_valid), 32'd0);

    // LI x5, 0x12345678 -> LUI + ADDI, input stalled between the words
    req("li1", 1'b1, 3'd0, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    chk("li1_stall", 32'(in_ready), 32'd0);
    expect_word("li1_w1", 32'h1234_52B7, 1'b0, 1'b0);
    expect_word("li1_w2", 32'h6782_8293, 1'b1, 1'b0);

    // LI x1, 0x800: lo rounds to -2048, hi to 1
    req("li2", 1'b1, 3'd0, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("li2_w1", 32'h0000_10B7, 1'b0, 1'b0);
    expect_word("li2_w2", 32'h8000_8093, 1'b1, 1'b0);

    // LI x1, 0x1000: low part zero -> LUI only
    req("li3", 1'b1, 3'd0, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
    expect_word("li3", 32'h0000_10B7, 1'b1, 1'b0);
    chk("li3_single", 32'(out_valid), 32'd0);

    // Branch with odd offset: bit 0 dropped, error flagged
    req("beq_odd", 1'b0, TYPE_B, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    expect_word("beq_odd", 32'h0000_0163, 1'b1, 1'b1);

    // JAL offset 2^20 does not fit the signed 21-bit field
    req("jal_big", 1'b0, TYPE_J, OP_JAL, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000);
    expect_word("jal_big", 32'h8000_006F, 1'b1, 1'b1);

    // SW x3, -4(x2)
    req("sw", 1'b0, TYPE_S, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC);
    expect_word("sw", 32'hFE31_2E23, 1'b1, 1'b0);

    // SLLI x1, x1, 31 is the largest legal shamt; SRAI by 32 is not
    req("slli", 1'b0, TYPE_I, OP_OP_IMM, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd31);
    expect_word("slli", 32'h01F0_9093, 1'b1, 1'b0);
    req("srai", 1'b0, TYPE_I, OP_OP_IMM, 3'b101, 7'h20, 5'd1, 5'd1, 5'd0, 32'd32);
    expect_word("srai", 32'h4000_D093, 1'b1, 1'b1);

    // Unknown format code
    req("badtype", 1'b0, 3'd7, OP_OP, 3'b000, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    expect_word("badtype", 32'h0000_0000, 1'b1, 1'b1);

    // Back-pressure across the LI pair
    out_ready = 1'b0;
    req("bp", 1'b1, 3'd0, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_inst", out_inst, 32'h1234_52B7);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    expect_word("bp_w1", 32'h1234_52B7, 1'b0, 1'b0);
    expect_word("bp_w2", 32'h6782_8293, 1'b1, 1'b0);
    chk("bp_nodup", 32'(out_valid), 32'd0);

    // Back-to-back raw requests, one word per cycle
    drive(1'b0, TYPE_R, OP_OP, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, TYPE_R, OP_OP, 3'b000, 7'h20, 5'd4, 5'd3, 5'd1, 32'd0);
    chk("b2b_w0", out_inst, 32'h0020_81B3);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, TYPE_I, OP_OP_IMM, 3'b000, 7'h00, 5'd2, 5'd2, 5'd0, 32'hFFFF_FFFF);
    chk("b2b_w1", out_inst, 32'h4011_8233);
    chk("b2b_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_w2", out_inst, 32'hFFF1_0113);
    chk("b2b_v2", 32'(out_valid), 32'd1);
    tick();
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // Reset while the LI tail is pending
    out_ready = 1'b0;
    req("rstmid", 1'b1, 3'd0, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    chk("rstmid_head", out_inst, 32'h1234_52B7);
    chk("rstmid_stall", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_inst", out_inst, 32'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rstmid_notail0", 32'(out_valid), 32'd0);
    tick();
    chk("rstmid_notail1", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
